// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX handshake, data-memory bus and write-back signals of the MEM/WB stage
interface mem_wb_stage_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   logic [4:0]  rd_write_back;
   logic [31:0] rd_value;
   logic        rd_write_en;
   logic        mem_err;

   modport slave (
      input  ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_funct3, ex_alu_result, ex_store_data, dmem_ack, dmem_rdata,
      output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
             rd_write_back, rd_value, rd_write_en, mem_err
   );

   modport master (
      output ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_funct3, ex_alu_result, ex_store_data, dmem_ack, dmem_rdata,
      input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
             rd_write_back, rd_value, rd_write_en, mem_err
   );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - RV32I memory-access / write-back stage with req/ack data memory
module mem_wb_stage (
   input  logic          clk,
   input  logic          rst,
   mem_wb_stage_if.slave bus
);
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_val_q, wb_val_d;
   logic        wb_en_q, wb_en_d;
   logic        err_q, err_d;

   logic        xfer, is_mem, f3_ok, align_ok;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   assign bus.ex_ready = !rst && (state_q == IDLE);
   assign xfer         = bus.ex_valid && bus.ex_ready;
   assign is_mem       = bus.ex_mem_read || bus.ex_mem_write;

   always_comb begin
      f3_ok    = 1'b0;
      align_ok = 1'b0;
      case (bus.ex_funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = bus.ex_mem_read;
         default:                f3_ok = 1'b0;
      endcase
      case (bus.ex_funct3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = !bus.ex_alu_result[0];
         2'b10:   align_ok = (bus.ex_alu_result[1:0] == 2'b00);
         default: align_ok = 1'b0;
      endcase
   end

   // Store data is replicated across lanes so memory only needs the strobes.
   always_comb begin
      st_wstrb = 4'b0000;
      st_wdata = bus.ex_store_data;
      case (bus.ex_funct3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << bus.ex_alu_result[1:0];
            st_wdata = {4{bus.ex_store_data[7:0]}};
         end
         2'b01: begin
            st_wstrb = bus.ex_alu_result[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{bus.ex_store_data[15:0]}};
         end
         default: st_wstrb = 4'b1111;
      endcase
   end

   always_comb begin
      ld_byte = 8'h00;
      case (lane_q)
         2'd0: ld_byte = bus.dmem_rdata[7:0];
         2'd1: ld_byte = bus.dmem_rdata[15:8];
         2'd2: ld_byte = bus.dmem_rdata[23:16];
         default: ld_byte = bus.dmem_rdata[31:24];
      endcase
      ld_half = lane_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_value = {24'h0, ld_byte};
         3'b101:  ld_value = {16'h0, ld_half};
         default: ld_value = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      funct3_d = funct3_q;
      lane_d   = lane_q;
      rd_d     = rd_q;
      wb_rd_d  = 5'd0;
      wb_val_d = 32'h0;
      wb_en_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer && is_mem) begin
               if (f3_ok && align_ok) begin
                  state_d  = MEM_WAIT;
                  req_d    = 1'b1;
                  we_d     = bus.ex_mem_write;
                  addr_d   = {bus.ex_alu_result[31:2], 2'b00};
                  wdata_d  = bus.ex_mem_write ? st_wdata : 32'h0;
                  wstrb_d  = bus.ex_mem_write ? st_wstrb : 4'b0000;
                  funct3_d = bus.ex_funct3;
                  lane_d   = bus.ex_alu_result[1:0];
                  rd_d     = bus.ex_rd;
               end else begin
                  err_d = 1'b1;
               end
            end else if (xfer && bus.ex_reg_write && bus.ex_rd != 5'd0) begin
               wb_en_d  = 1'b1;
               wb_rd_d  = bus.ex_rd;
               wb_val_d = bus.ex_alu_result;
            end
         end
         default: begin
            if (bus.dmem_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               if (!we_q && rd_q != 5'd0) begin
                  wb_en_d  = 1'b1;
                  wb_rd_d  = rd_q;
                  wb_val_d = ld_value;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         wstrb_q  <= 4'b0000;
         funct3_q <= 3'b000;
         lane_q   <= 2'b00;
         rd_q     <= 5'd0;
         wb_rd_q  <= 5'd0;
         wb_val_q <= 32'h0;
         wb_en_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         funct3_q <= funct3_d;
         lane_q   <= lane_d;
         rd_q     <= rd_d;
         wb_rd_q  <= wb_rd_d;
         wb_val_q <= wb_val_d;
         wb_en_q  <= wb_en_d;
         err_q    <= err_d;
      end
   end

   assign bus.dmem_req      = req_q;
   assign bus.dmem_we       = we_q;
   assign bus.dmem_addr     = addr_q;
   assign bus.dmem_wdata    = wdata_q;
   assign bus.dmem_wstrb    = wstrb_q;
   assign bus.rd_write_back = wb_rd_q;
   assign bus.rd_value      = wb_val_q;
   assign bus.rd_write_en   = wb_en_q;
   assign bus.mem_err       = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   busy;

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd_wr, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sdata);
      bus.ex_valid      = 1'b1;
      bus.ex_mem_read   = rd_en;
      bus.ex_mem_write  = wr_en;
      bus.ex_reg_write  = rd_wr;
      bus.ex_funct3     = f3;
      bus.ex_rd         = rd;
      bus.ex_alu_result = alu;
      bus.ex_store_data = sdata;
   endtask

   // Transfer already driven; ack comes after wait_n idle request cycles.
   task automatic mem_op(input int wait_n, input logic [31:0] rdata, output int low);
      step();
      bus.ex_valid   = 1'b0;
      bus.dmem_rdata = rdata;
      low = 0;
      for (int i = 0; i <= wait_n; i++) begin
         bus.dmem_ack = (i == wait_n);
         if (!bus.ex_ready) low++;
         step();
      end
      bus.dmem_ack = 1'b0;
   endtask

   initial begin
      bus.ex_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b0;
      bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0; bus.ex_funct3 = 3'b000;
      bus.ex_alu_result = 32'h0; bus.ex_store_data = 32'h0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;

      step(); step();
      check("rst_ready", {31'h0, bus.ex_ready}, 32'h0);
      check("rst_req", {31'h0, bus.dmem_req}, 32'h0);
      check("rst_addr", bus.dmem_addr, 32'h0);
      check("rst_wben", {31'h0, bus.rd_write_en}, 32'h0);
      check("rst_err", {31'h0, bus.mem_err}, 32'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'h0, bus.ex_ready}, 32'h1);

      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("add_rd", {27'h0, bus.rd_write_back}, 32'd5);
      check("add_val", bus.rd_value, 32'h1234);
      check("add_en", {31'h0, bus.rd_write_en}, 32'h1);
      step();
      check("add_rd_clr", {27'h0, bus.rd_write_back}, 32'd0);
      check("add_val_clr", bus.rd_value, 32'h0);
      check("add_en_clr", {31'h0, bus.rd_write_en}, 32'h0);

      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd1, 32'h1111_0001, 32'h0);
      step();
      check("b2b_a_val", bus.rd_value, 32'h1111_0001);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd2, 32'h2222_0002, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("b2b_b_rd", {27'h0, bus.rd_write_back}, 32'd2);
      check("b2b_b_val", bus.rd_value, 32'h2222_0002);

      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("add_x0_en", {31'h0, bus.rd_write_en}, 32'h0);
      check("add_x0_val", bus.rd_value, 32'h0);

      drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd7, 32'h0000_0103, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("lb_req", {31'h0, bus.dmem_req}, 32'h1);
      check("lb_addr", bus.dmem_addr, 32'h100);
      check("lb_we", {31'h0, bus.dmem_we}, 32'h0);
      check("lb_wstrb", {28'h0, bus.dmem_wstrb}, 32'h0);
      bus.dmem_rdata = 32'h80FF_0000;
      busy = 0;
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ack = (i == 3);
         if (!bus.ex_ready) busy++;
         step();
      end
      bus.dmem_ack = 1'b0;
      check("lb_busy", busy, 32'd4);
      check("lb_req_drop", {31'h0, bus.dmem_req}, 32'h0);
      check("lb_en", {31'h0, bus.rd_write_en}, 32'h1);
      check("lb_rd", {27'h0, bus.rd_write_back}, 32'd7);
      check("lb_val", bus.rd_value, 32'hFFFF_FF80);
      check("lb_ready", {31'h0, bus.ex_ready}, 32'h1);

      drive(1'b1, 1'b1, 1'b0, 3'b100, 5'd8, 32'h0000_0103, 32'h0);
      mem_op(0, 32'h80FF_0000, busy);
      check("lbu_busy", busy, 32'd1);
      check("lbu_val", bus.rd_value, 32'h0000_0080);

      drive(1'b1, 1'b1, 1'b0, 3'b001, 5'd9, 32'h0000_0002, 32'h0);
      mem_op(1, 32'h8001_1234, busy);
      check("lh_val", bus.rd_value, 32'hFFFF_8001);
      drive(1'b1, 1'b1, 1'b0, 3'b101, 5'd9, 32'h0000_0002, 32'h0);
      mem_op(0, 32'h8001_1234, busy);
      check("lhu_val", bus.rd_value, 32'h0000_8001);
      drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_0040, 32'h0);
      mem_op(2, 32'hCAFE_F00D, busy);
      check("lw_val", bus.rd_value, 32'hCAFE_F00D);
      check("lw_busy", busy, 32'd3);

      drive(1'b0, 1'b0, 1'b1, 3'b001, 5'd0, 32'h0000_0202, 32'hABCD_5678);
      step();
      bus.ex_valid = 1'b0;
      check("sh_we", {31'h0, bus.dmem_we}, 32'h1);
      check("sh_addr", bus.dmem_addr, 32'h200);
      check("sh_wstrb", {28'h0, bus.dmem_wstrb}, 32'hC);
      check("sh_wdata", bus.dmem_wdata, 32'h5678_5678);
      step();
      check("sh_hold_req", {31'h0, bus.dmem_req}, 32'h1);
      check("sh_hold_wdata", bus.dmem_wdata, 32'h5678_5678);
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
      check("sh_no_wb", {31'h0, bus.rd_write_en}, 32'h0);
      check("sh_req_drop", {31'h0, bus.dmem_req}, 32'h0);

      drive(1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h0000_0101, 32'h0000_00AB);
      step();
      bus.ex_valid = 1'b0;
      check("sb_wstrb", {28'h0, bus.dmem_wstrb}, 32'h2);
      check("sb_wdata", bus.dmem_wdata, 32'hABAB_ABAB);
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;

      drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0006, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("lw_mis_err", {31'h0, bus.mem_err}, 32'h1);
      check("lw_mis_req", {31'h0, bus.dmem_req}, 32'h0);
      check("lw_mis_en", {31'h0, bus.rd_write_en}, 32'h0);
      check("lw_mis_ready", {31'h0, bus.ex_ready}, 32'h1);
      step();
      check("lw_mis_err_pulse", {31'h0, bus.mem_err}, 32'h0);

      drive(1'b0, 1'b0, 1'b1, 3'b100, 5'd0, 32'h0000_0010, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("sbu_illegal_err", {31'h0, bus.mem_err}, 32'h1);
      check("sbu_illegal_req", {31'h0, bus.dmem_req}, 32'h0);
      step();

      drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd0, 32'h0000_0010, 32'h0);
      mem_op(0, 32'hDEAD_BEEF, busy);
      check("ld_x0_en", {31'h0, bus.rd_write_en}, 32'h0);
      check("ld_x0_rd", {27'h0, bus.rd_write_back}, 32'h0);
      check("ld_x0_val", bus.rd_value, 32'h0);

      drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd9, 32'h0000_0020, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("abort_req_pre", {31'h0, bus.dmem_req}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("abort_req_async", {31'h0, bus.dmem_req}, 32'h0);
      check("abort_ready", {31'h0, bus.ex_ready}, 32'h0);
      step();
      rst = 1'b0;
      bus.dmem_ack = 1'b1;
      bus.dmem_rdata = 32'h1234_5678;
      step();
      bus.dmem_ack = 1'b0;
      check("abort_no_wb", {31'h0, bus.rd_write_en}, 32'h0);
      check("abort_no_req", {31'h0, bus.dmem_req}, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd3, 32'h0000_0055, 32'h0);
      step();
      bus.ex_valid = 1'b0;
      check("post_abort_rd", {27'h0, bus.rd_write_back}, 32'd3);
      check("post_abort_val", bus.rd_value, 32'h55);
      check("post_abort_en", {31'h0, bus.rd_write_en}, 32'h1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 5-stage RV32I pipeline. Accepts one retiring instruction per handshake from EX. Performs the load/store against a variable-latency data memory over a req/ack interface, with byte/half/word alignment and sign/zero extension. Drives the registered write-back destination and value consumed by the register file and the decode-side forwarding logic.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage accepts the instruction this cycle
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (never both with mem_read)
- ex_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ex_alu_result  in  32  ALU result, or effective address for memory ops
- ex_store_data  in  32  rs2 value for stores
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_ack  in  1  request completed; dmem_rdata valid for loads
- dmem_rdata  in  32  raw word read data
- rd_write_back  out  5  write-back register index
- rd_value  out  32  write-back value
- rd_write_en  out  1  write-back valid
- mem_err  out  1  one-cycle pulse: misaligned or illegal-funct3 access

## Operation
- FSM states: IDLE, MEM_WAIT.
- ex_ready = !rst && state==IDLE. Transfer occurs when ex_valid && ex_ready.
- Non-memory transfer: at the next edge, rd_write_back=ex_rd, rd_value=ex_alu_result, rd_write_en=ex_reg_write && ex_rd!=0; state stays IDLE.
- Memory transfer, legal: at the next edge, register the request (dmem_req=1, dmem_we, dmem_addr={addr[31:2],2'b00}, wdata, wstrb) and go to MEM_WAIT. Request fields hold stable until ack.
- Alignment legality: w requires addr[1:0]==0; h/hu requires addr[0]==0; b/bu always legal. funct3 011/110/111 is illegal for memory ops, as is 100/101 for stores.
- Illegal or misaligned transfer: no memory request; mem_err=1 for the next cycle only; no write-back (rd_write_en=0); state stays IDLE.
- Stores: sb: wstrb=0001<<addr[1:0], wdata={4{data[7:0]}}. sh: wstrb=0011 (addr[1]=0) or 1100, wdata={2{data[15:0]}}. sw: wstrb=1111, wdata=data.
- Loads: select the lane by the registered addr[1:0], then sign-extend (b, h) or zero-extend (bu, hu).
- MEM_WAIT with dmem_ack: at the next edge, dmem_req=0 and state=IDLE. Load: write-back outputs carry rd / extended data, with rd_write_en=(rd!=0). Store: no write-back.
- When write-back is not valid, rd_write_back=0 and rd_value=0. Consequently, a forwarding match on index 0 always yields 0.
- dmem_ack in IDLE is ignored.

## Timing
- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, rd_write_back=0, rd_value=0, rd_write_en=0, mem_err=0, state=IDLE. ex_ready=0 while rst is high.
- rst asserted in MEM_WAIT aborts immediately: dmem_req drops asynchronously. No write-back is produced for the aborted op, and a late ack is ignored.
- All outputs except ex_ready are registered.
- Non-memory op: write-back valid 1 cycle after transfer; throughput 1/cycle.
- Memory op: dmem_req rises 1 cycle after transfer; the earliest ack is in that same cycle. Write-back is valid 1 cycle after the ack cycle. The next transfer is possible the cycle after the ack, so minimum occupancy is 2 cycles.
- rd_write_en, mem_err: high for exactly one cycle per event.

## Test plan
- Reset, then ADD with rd=5, value 0x0000_1234 -> next cycle rd_write_back=5, rd_value=0x1234, rd_write_en=1. One cycle later all three are 0.
- lb at addr 0x103, rdata=0x80FF_0000, ack after 3 wait cycles -> dmem_addr=0x100, ex_ready low 4 cycles; write-back rd_value=0xFFFF_FF80. lbu on the same data -> 0x0000_0080.
- sh of 0xABCD_5678 at 0x202 -> dmem_we=1, wstrb=1100, wdata=0x5678_5678, no rd_write_en.
- lw at 0x0000_0006 -> mem_err pulses 1 cycle, dmem_req stays 0, rd_write_en=0.
- Load to rd=0 -> rd_write_en=0, rd_write_back=0, rd_value=0.
- rst pulsed during MEM_WAIT, then ack arrives -> dmem_req=0 immediately, no write-back. The next ADD completes normally.
